// File: rtl/dct_mac_pipe.sv
// Pipelined signed multiply-accumulate for the forward DCT: one product stage, one
// accumulate stage, then round/shift/saturate into a valid/ready output register.
module dct_mac_pipe #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 11,
    parameter int TERMS  = 8,
    parameter int SHIFT  = 4,
    parameter int OUT_W  = 12,
    localparam int CNT_W  = (TERMS > 1) ? $clog2(TERMS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [COEF_W-1:0] in_coef,
    input  logic                     round_en,
    input  logic                     abort,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    output logic [CNT_W-1:0]         term_cnt
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TERMS);
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(TERMS - 1);
    localparam logic signed [ACC_W-1:0] RND      = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] OMAX     = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OMIN     = ~OMAX;

    // Handshake: a pair transfers on in_valid & in_ready, a result on out_valid & out_ready.
    // A held result (out_valid & ~out_ready) freezes every pipeline stage.
    logic                     stall, adv, accept, last_term;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  prod_ext, sum_c, shr_c;

    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     p_vld_q, p_vld_d, p_last_q, p_last_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     round_en_q, round_en_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     out_valid_q, out_valid_d, out_sat_q, out_sat_d;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;

    assign stall     = out_valid_q & ~out_ready;
    assign adv       = ~stall;
    assign accept    = in_valid & adv;
    assign last_term = (cnt_q == LAST_CNT);

    assign prod_c   = PROD_W'(in_data) * PROD_W'(in_coef);
    assign prod_ext = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
    assign sum_c    = acc_q + prod_ext + (round_en_q ? RND : '0);
    assign shr_c    = sum_c >>> SHIFT;

    always_comb begin
        prod_d      = prod_q;
        p_vld_d     = p_vld_q;
        p_last_d    = p_last_q;
        acc_d       = acc_q;
        round_en_d  = round_en_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (abort) begin
            acc_d   = '0;
            cnt_d   = '0;
            p_vld_d = 1'b0;
        end else if (adv) begin
            if (accept) begin
                prod_d   = prod_c;
                p_vld_d  = 1'b1;
                p_last_d = last_term;
                cnt_d    = last_term ? '0 : cnt_q + 1'b1;
                if (last_term) round_en_d = round_en;
            end else begin
                p_vld_d = 1'b0;
            end

            if (p_vld_q) begin
                if (!p_last_q) begin
                    acc_d = acc_q + prod_ext;
                end else begin
                    // A loaded result overrides the handshake clear above.
                    acc_d       = '0;
                    out_valid_d = 1'b1;
                    if (shr_c > OMAX) begin
                        out_data_d = OMAX[OUT_W-1:0];
                        out_sat_d  = 1'b1;
                    end else if (shr_c < OMIN) begin
                        out_data_d = OMIN[OUT_W-1:0];
                        out_sat_d  = 1'b1;
                    end else begin
                        out_data_d = shr_c[OUT_W-1:0];
                        out_sat_d  = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q      <= '0;
            p_vld_q     <= 1'b0;
            p_last_q    <= 1'b0;
            acc_q       <= '0;
            round_en_q  <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            p_vld_q     <= p_vld_d;
            p_last_q    <= p_last_d;
            acc_q       <= acc_d;
            round_en_q  <= round_en_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_dct_mac_pipe.sv
// Directed bench for dct_mac_pipe: hand-computed results queued in exp_q and
// matched against every output handshake, plus direct checks of control outputs.
module tb_dct_mac_pipe;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_data;
    logic signed [10:0] in_coef;
    logic               round_en;
    logic               abort;
    logic               out_valid;
    logic               out_ready;
    logic signed [11:0] out_data;
    logic               out_sat;
    logic [2:0]         term_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [12:0] exp_q[$];

    dct_mac_pipe #(
        .DATA_W(8), .COEF_W(11), .TERMS(8), .SHIFT(4), .OUT_W(12)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_coef(in_coef),
        .round_en(round_en), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat),
        .term_cnt(term_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [12:0] pack(input bit sat, input int v);
        return {sat, v[11:0]};
    endfunction

    // Scoreboard: each output handshake consumes one expected {sat, data}.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("extra_result", 1, 0);
            else check("result", int'({out_sat, out_data}), int'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input int d, input int c, input bit rnd, input int n,
                              input bit gaps, input bit chk_cnt);
        for (int i = 0; i < n; i++) begin
            bit ok;
            int guard;
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
            in_valid = 1'b1;
            in_data  = 8'(d);
            in_coef  = 11'(c);
            round_en = rnd;
            guard    = 0;
            ok       = 1'b0;
            while (!ok && guard < 100) begin
                @(negedge clk);
                if (chk_cnt && guard == 0) check("term_cnt", int'(term_cnt), i % 8);
                ok = in_ready;
                tick();
                guard++;
            end
            if (!ok) check("accept_timeout", 1, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 50) begin
            tick();
            guard++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_data"},  int'(out_data), 0);
        check({tag, "_out_sat"},   int'(out_sat), 0);
        check({tag, "_term_cnt"},  int'(term_cnt), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_coef = '0;
        round_en = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic sum with latency and single-cycle valid: 8*16 >> 4 = 8
        exp_q.push_back(pack(0, 8));
        send_block(16, 1, 0, 8, 0, 0);
        check("lat_early", int'(out_valid), 0);
        tick();
        check("lat_valid", int'(out_valid), 1);
        check("basic_data", int'(out_data), 8);
        check("basic_sat", int'(out_sat), 0);
        tick();
        check("one_cycle", int'(out_valid), 0);
        drain();

        // Rounding: (8 + 8) >> 4 = 1, 8 >> 4 = 0
        exp_q.push_back(pack(0, 1));
        send_block(1, 1, 1, 8, 0, 0);
        exp_q.push_back(pack(0, 0));
        send_block(1, 1, 0, 8, 0, 0);
        drain();

        // Saturation: 8*131072 >> 4 = 65536 -> 2047; 8*(-130944) >> 4 = -65472 -> -2048
        exp_q.push_back(pack(1, 2047));
        send_block(-128, -1024, 0, 8, 0, 0);
        exp_q.push_back(pack(1, -2048));
        send_block(-128, 1023, 0, 8, 0, 0);
        drain();

        // Backpressure: first result held 5 cycles while the second block waits
        out_ready = 1'b0;
        exp_q.push_back(pack(0, 8));
        exp_q.push_back(pack(0, 16));
        fork
            begin
                send_block(16, 1, 0, 8, 0, 0);
                send_block(32, 1, 0, 8, 0, 0);
            end
            begin
                int guard = 0;
                @(negedge clk);
                while (!out_valid && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                check("stall_seen", int'(out_valid), 1);
                for (int k = 0; k < 5; k++) begin
                    check("stall_in_ready", int'(in_ready), 0);
                    check("stall_hold", int'(out_data), 8);
                    @(negedge clk);
                end
                tick();
                out_ready = 1'b1;
            end
        join
        drain();

        // Abort after 3 terms; the pair presented during abort is dropped
        send_block(16, 1, 0, 3, 0, 0);
        abort = 1'b1; in_valid = 1'b1; in_data = 8'(100); in_coef = 11'(1);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        check("abort_cnt", int'(term_cnt), 0);
        exp_q.push_back(pack(0, 8));
        send_block(16, 1, 0, 8, 0, 0);
        drain();

        // Reset (with abort) after 5 terms
        send_block(16, 1, 0, 5, 0, 0);
        rst_n = 1'b0; abort = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst_n = 1'b1; abort = 1'b0;
        exp_q.push_back(pack(0, 8));
        send_block(16, 1, 0, 8, 0, 0);
        drain();

        // term_cnt sequence and random gaps: 8*(20*3) >> 4 = 30
        exp_q.push_back(pack(0, 30));
        send_block(20, 3, 0, 8, 1, 1);
        drain();
        check("wrap_cnt", int'(term_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dct_mac_pipe.md
# dct_mac_pipe

Parametrised, pipelined signed multiply-accumulate unit for the forward-DCT datapath of the JPEG encoder. It is the generalised successor to the fixed per-unit MAC inside each DCT block. It accepts one sample/coefficient pair per cycle, registers the product, and accumulates `TERMS` products into one DCT coefficient. It then rounds, shifts and saturates the sum and presents it on a valid/ready output. Adds backpressure, abort, selectable rounding and saturation flagging, none of which the fixed unit has.

## Interface
- `DATA_W`, 8: signed input sample width.
- `COEF_W`, 11: signed coefficient width.
- `TERMS`, 8: products per result, ≥2.
- `SHIFT`, 4: arithmetic right shift applied to the final sum, ≥1.
- `OUT_W`, 12: signed output width.
- Derived (localparam): `PROD_W = DATA_W+COEF_W`, `ACC_W = PROD_W + clog2(TERMS)`.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: sample/coefficient pair valid.
- `in_ready` out 1: unit can accept a pair this cycle.
- `in_data` in DATA_W: signed sample.
- `in_coef` in COEF_W: signed coefficient.
- `round_en` in 1: add rounding constant before the shift; sampled with the last term.
- `abort` in 1: discard the partial accumulation.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out OUT_W: signed result.
- `out_sat` out 1: result was clipped.
- `term_cnt` out clog2(TERMS): count of terms accepted in the current block.

## Operation
- `stall = out_valid & ~out_ready`; `adv = ~stall`; `in_ready = adv`.
- Accept occurs when `in_valid & in_ready`. On accept:
  - `P <= in_data*in_coef` (signed, full PROD_W).
  - `p_vld <= 1`.
  - `p_last <= (term_cnt == TERMS-1)`.
  - `term_cnt` increments, wrapping to 0 after TERMS-1.
- When `adv` and no accept: `p_vld <= 0`. When `stall`: P, p_vld, p_last and acc hold.
- Accumulate stage, when `adv & p_vld`:
  - If `~p_last`: `acc <= acc + P`.
  - If `p_last`:
    - `s = acc + P + (round_en_q ? 2^(SHIFT-1) : 0)`; `r = s >>> SHIFT`.
    - `out_data <= clip(r)` to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
    - `out_sat <= (r` out of range`)`.
    - `out_valid <= 1`; `acc <= 0`.
- `round_en_q` is captured on the accept of the last term.
- Output handshake: `out_valid & out_ready` clears `out_valid` unless a new result loads on the same edge. A new result loads then, because `adv = 1`.
- `out_data` and `out_sat` hold while `out_valid & ~out_ready`.
- `abort` (synchronous, priority over accept and accumulate):
  - Sets `acc <= 0`, `term_cnt <= 0`, `p_vld <= 0`.
  - Does not touch `out_valid` or `out_data`.
  - An `in_valid` in the abort cycle is dropped.
- All sums are in ACC_W signed; no intermediate overflow is possible for legal widths.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_data=0`, `out_sat=0`, `term_cnt=0`; acc, P, p_vld and p_last are 0.
- Throughput: one pair per cycle with no stall; blocks run back-to-back with no bubble.
- Latency: with no stall, `out_valid` rises at the edge after the edge that accepts the last term.
- Stall freezes the whole pipeline; no pairs are lost or duplicated.
- Reset mid-block discards all state. The first pair after reset starts a new block.
- Asserting `abort` and `rst_n=0` together behaves as reset.

## Test plan
- Basic sum: 8 pairs of data=16, coef=1, `round_en=0`, `out_ready=1`.
  - Required: `out_data=8`, `out_sat=0`, `out_valid` for one cycle, one edge after the 8th accept.
- Rounding: 8 pairs of data=1, coef=1.
  - With `round_en=1`: `out_data=1`.
  - Repeated with `round_en=0`: `out_data=0`.
- Saturation:
  - 8 pairs of data=−128, coef=−1024: `out_data=2047`, `out_sat=1`.
  - data=−128, coef=1023 ×8: `out_data=−2048`, `out_sat=1`.
- Backpressure: two back-to-back blocks (data=16, coef=1, then data=32, coef=1) with `out_ready=0` for 5 cycles after the first result.
  - Required: `in_ready=0` while stalled; first result 8 held.
  - Then 16 delivered, with no lost or extra terms.
- Abort and reset:
  - Abort after 3 terms, then 8 terms of data=16, coef=1: result 8.
  - Same sequence with `rst_n=0` after 5 terms: all outputs return to reset values; next full block yields 8.
- Wrap and `term_cnt`:
  - `term_cnt` reads 0..7 across a block and returns to 0.
  - Random `in_valid` gaps within a block do not change the result.
